// File: rtl/seg_scan_capture.sv
// Recovers the 16-bit hex value shown on a scanned 4-digit seven-segment bus.
// The an/seg pair is synchronized and glitch-filtered, then each dwell is decoded once.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic [3:0]  digit_seen,
  output logic        digit_err
);

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYC);
  localparam logic [7:0] CNT_HIT  = 8'(STABLE_CYC - 1);

  logic [3:0]  an_meta, an_sync, an_prev;
  logic [6:0]  seg_meta, seg_sync, seg_prev;
  logic [7:0]  cnt;
  logic        accepted;
  logic [15:0] shadow;

  logic        same, stable;
  logic        dec_ok;
  logic [3:0]  dec_nib;
  logic        sel_ok;
  logic [1:0]  sel_idx;
  logic        cap, bad, done;
  logic [3:0]  seen_next;

  assign same   = (an_sync == an_prev) && (seg_sync == seg_prev);
  assign stable = same && !accepted && (cnt == CNT_HIT);

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (seg_sync)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Only a single low anode selects a digit; blank and multi-anode dwells are ignored.
  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (an_sync)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  assign cap  = stable && sel_ok && dec_ok;
  assign bad  = stable && sel_ok && !dec_ok;
  assign done = (digit_seen == 4'hF);

  // A capture on the completion cycle belongs to the next frame.
  always_comb begin
    seen_next = done ? 4'h0 : digit_seen;
    if (cap) seen_next[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_meta     <= 4'hF;
      an_sync     <= 4'hF;
      an_prev     <= 4'hF;
      seg_meta    <= 7'h7F;
      seg_sync    <= 7'h7F;
      seg_prev    <= 7'h7F;
      cnt         <= 8'd0;
      accepted    <= 1'b0;
      shadow      <= 16'h0000;
      value       <= 16'h0000;
      frame_valid <= 1'b0;
      digit_seen  <= 4'h0;
      digit_err   <= 1'b0;
    end else begin
      an_meta  <= an;
      an_sync  <= an_meta;
      an_prev  <= an_sync;
      seg_meta <= seg;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;

      if (!same) begin
        cnt      <= 8'd0;
        accepted <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
        if (stable) accepted <= 1'b1;
      end

      digit_err   <= bad;
      frame_valid <= done;
      if (done) value <= shadow;
      if (cap) shadow[{sel_idx, 2'b00} +: 4] <= dec_nib;
      digit_seen <= seen_next;
    end
  end

endmodule
